mem_access_ctrl: RTL

Sequential bridge between the CISC core's load/store unit and the 256-bit-line `memory` SRAM block. Converts 8/16/32-bit core accesses into full-line SRAM reads and read-modify-write line writes, and handles alignment checks and the write-completion wait. Sits directly upstream of `memory` and drives its `DataIn`, `Address`, `MemEnable` and `MemReadWrite` inputs.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/lane_merge.sv | 40 ++++
 rtl/mem_access_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access controller: geometry, request size codes and FSM states.
package mem_pkg;

  localparam int LINE_W   = 256;
  localparam int LINE_AW  = 7;
  localparam int OFFSET_W = 5;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_WR_WAIT  = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  // True when the access can never touch the SRAM: bad size code or misaligned offset.
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [OFFSET_W-1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return |offset[1:0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Byte-lane steering for one SRAM line: merges store data into the line and extracts load data.
module lane_merge #(
  parameter int LINE_W = mem_pkg::LINE_W
) (
  input  logic [LINE_W-1:0]            line_in,
  input  logic [mem_pkg::OFFSET_W-1:0] offset,
  input  logic [1:0]                   size,
  input  logic [31:0]                  store_data,
  output logic [LINE_W-1:0]            merged_line,
  output logic [31:0]                  load_data
);
  import mem_pkg::*;

  logic [2:0]          n_bytes;
  logic [OFFSET_W-1:0] lane;

  always_comb begin
    case (size)
      SZ_BYTE: n_bytes = 3'd1;
      SZ_HALF: n_bytes = 3'd2;
      SZ_WORD: n_bytes = 3'd4;
      default: n_bytes = 3'd0;
    endcase
  end

  // Lanes run little-endian from the offset upward; aligned accesses never wrap.
  always_comb begin
    merged_line = line_in;
    load_data   = '0;
    lane        = offset;
    for (int k = 0; k < 4; k++) begin
      lane = offset + OFFSET_W'(k);
      if (3'(k) < n_bytes) begin
        merged_line[{lane, 3'b000} +: 8] = store_data[8*k +: 8];
        load_data[8*k +: 8]              = line_in[{lane, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Core load/store to 256-bit-line SRAM bridge with read-modify-write stores and write timeout.
// Define LINE_BUFFER_EN to add a one-entry write-through line buffer.
module mem_access_ctrl #(
  parameter int LINE_W     = mem_pkg::LINE_W,
  parameter int LINE_AW    = mem_pkg::LINE_AW,
  parameter int WR_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [11:0]       ReqAddr,
  input  logic [1:0]        ReqSize,
  input  logic [31:0]       ReqData,
  output logic              RespValid,
  output logic              RespErr,
  output logic [31:0]       RespData,
  input  logic [LINE_W-1:0] MemData,
  input  logic              MemWriteDone,
  output logic [LINE_W-1:0] MemDataIn,
  output logic [LINE_AW-1:0] MemAddress,
  output logic              MemEnable,
  output logic              MemReadWrite
);
  import mem_pkg::*;

  localparam int CNT_W = $clog2(WR_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                req_write_q, req_write_d;
  logic [11:0]         req_addr_q, req_addr_d;
  logic [1:0]          req_size_q, req_size_d;
  logic [31:0]         req_data_q, req_data_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [LINE_AW-1:0]  req_line;
  logic [OFFSET_W-1:0] req_off;
  logic [LINE_W-1:0]   merged_line;
  logic [31:0]         load_data;
  logic                in_illegal;

`ifdef LINE_BUFFER_EN
  logic                buf_valid_q, buf_valid_d;
  logic [LINE_AW-1:0]  buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]   buf_line_q, buf_line_d;
`endif

  assign req_line   = req_addr_q[LINE_AW+OFFSET_W-1:OFFSET_W];
  assign req_off    = req_addr_q[OFFSET_W-1:0];
  assign in_illegal = access_illegal(ReqSize, ReqAddr[OFFSET_W-1:0]);

  lane_merge #(.LINE_W(LINE_W)) u_lane_merge (
    .line_in     (line_q),
    .offset      (req_off),
    .size        (req_size_q),
    .store_data  (req_data_q),
    .merged_line (merged_line),
    .load_data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    req_write_d = req_write_q;
    req_addr_d  = req_addr_q;
    req_size_d  = req_size_q;
    req_data_d  = req_data_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef LINE_BUFFER_EN
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_line_d  = buf_line_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          req_write_d = ReqWrite;
          req_addr_d  = ReqAddr;
          req_size_d  = ReqSize;
          req_data_d  = ReqData;
          cnt_d       = '0;
          err_d       = 1'b0;
          if (in_illegal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
`ifdef LINE_BUFFER_EN
            if (ReqWrite) buf_valid_d = 1'b0;
          end else if (buf_valid_q &&
                       buf_tag_q == ReqAddr[LINE_AW+OFFSET_W-1:OFFSET_W]) begin
            line_d  = buf_line_q;
            state_d = ReqWrite ? ST_WR_ISSUE : ST_RESP;
`endif
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        line_d  = MemData;
        state_d = req_write_q ? ST_WR_ISSUE : ST_RESP;
`ifdef LINE_BUFFER_EN
        buf_valid_d = 1'b1;
        buf_tag_d   = req_line;
        buf_line_d  = MemData;
`endif
      end
      ST_WR_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WR_WAIT;
`ifdef LINE_BUFFER_EN
        buf_valid_d = 1'b1;
        buf_tag_d   = req_line;
        buf_line_d  = merged_line;
`endif
      end
      // A completion in the same cycle the limit is reached still counts as success.
      ST_WR_WAIT: begin
        if (MemWriteDone) begin
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
`ifdef LINE_BUFFER_EN
          buf_valid_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ReqReady     = (state_q == ST_IDLE);
    RespValid    = (state_q == ST_RESP);
    RespErr      = (state_q == ST_RESP) && err_q;
    RespData     = '0;
    MemDataIn    = '0;
    MemAddress   = '0;
    MemEnable    = 1'b0;
    MemReadWrite = 1'b0;
    if (state_q == ST_RESP && !err_q && !req_write_q) RespData = load_data;
    case (state_q)
      ST_RD_ISSUE: begin
        MemEnable    = 1'b1;
        MemReadWrite = 1'b1;
        MemAddress   = req_line;
      end
      ST_WR_ISSUE, ST_WR_WAIT: begin
        MemEnable  = 1'b1;
        MemAddress = req_line;
        MemDataIn  = merged_line;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_size_q  <= '0;
      req_data_q  <= '0;
      line_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_write_q <= req_write_d;
      req_addr_q  <= req_addr_d;
      req_size_q  <= req_size_d;
      req_data_q  <= req_data_d;
      line_q      <= line_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

`ifdef LINE_BUFFER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_line_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_line_q  <= buf_line_d;
    end
  end
`endif

endmodule
